ac97_frame_receiver: RTL

- Deserialises the AC'97 SDATA_IN stream that the codec returns to the controller. This is the receive path that complements the existing AC'97 frame generator, which drives SDATA_OUT and SYNC.
- Uses our own outgoing ac97_synch for frame alignment and splits each 256-bit frame into tag, status-register and PCM-capture fields.
- Feeds register read-back and ADC audio to downstream logic in the ac97_bit_clock domain.

---
 rtl/ac97_frame_receiver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ac97_frame_receiver.sv
// AC'97 SDATA_IN receive path: aligns to our outgoing SYNC and extracts the
// tag, status read-back (slots 1-2) and PCM capture (slots 3-4) fields.
module ac97_frame_receiver #(
  parameter int unsigned PCM_BITS = 20,
  parameter int unsigned USE_TAGS = 1
) (
  input  logic                ac97_bit_clock,
  input  logic                reset,
  input  logic                ac97_synch,
  input  logic                ac97_sdata_in,
  output logic                codec_ready,
  output logic                status_valid,
  output logic [6:0]          status_addr,
  output logic [15:0]         status_data,
  output logic                pcm_valid,
  output logic [PCM_BITS-1:0] pcm_left,
  output logic [PCM_BITS-1:0] pcm_right,
  output logic                frame_error,
  output logic                locked
);

  localparam int unsigned SLOT_W = 20;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0] TAG_END  = CNT_W'(15);
  localparam logic [CNT_W-1:0] S1_END   = CNT_W'(35);
  localparam logic [CNT_W-1:0] S2_END   = CNT_W'(55);
  localparam logic [CNT_W-1:0] S3_END   = CNT_W'(75);
  localparam logic [CNT_W-1:0] S4_END   = CNT_W'(95);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(255);

  localparam bit IGNORE_TAGS = (USE_TAGS == 0);

  typedef enum logic {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } state_e;

  state_e              state_q;
  logic                sync_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SLOT_W-2:0]   shift_q;
  logic [SLOT_W-1:0]   shift_d;
  logic [4:0]          tag_q;    // tag bits 15..11: ready, slot 1..4 valid
  logic [6:0]          addr_q;
  logic [15:0]         data_q;
  logic [PCM_BITS-1:0] left_q;
  logic [PCM_BITS-1:0] right_q;
  logic                sync_edge;
  logic                status_ok;
  logic                pcm_ok;

  // Incoming bit joins the shifter; rising SYNC marks the next bit as bit 0.
  always_comb begin
    shift_d   = {shift_q, ac97_sdata_in};
    sync_edge = ac97_synch & ~sync_q;
    status_ok = IGNORE_TAGS || (tag_q[3] && tag_q[2]);
    pcm_ok    = IGNORE_TAGS || (tag_q[1] && tag_q[0]);
  end

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      state_q      <= HUNT;
      sync_q       <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      tag_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      codec_ready  <= 1'b0;
      status_valid <= 1'b0;
      status_addr  <= '0;
      status_data  <= '0;
      pcm_valid    <= 1'b0;
      pcm_left     <= '0;
      pcm_right    <= '0;
      frame_error  <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sync_q       <= ac97_synch;
      status_valid <= 1'b0;
      pcm_valid    <= 1'b0;
      frame_error  <= 1'b0;
      case (state_q)
        HUNT: begin
          if (sync_edge) begin
            state_q <= RECEIVE;
            cnt_q   <= '0;
          end
        end
        RECEIVE: begin
          shift_q <= shift_d[SLOT_W-2:0];
          if (cnt_q == LAST_BIT) begin
            // Frame complete: publish the fields gated by their valid tags.
            codec_ready <= tag_q[4];
            if (status_ok) begin
              status_addr  <= addr_q;
              status_data  <= data_q;
              status_valid <= 1'b1;
            end
            if (pcm_ok) begin
              pcm_left  <= left_q;
              pcm_right <= right_q;
              pcm_valid <= 1'b1;
            end
            cnt_q <= '0;
            if (sync_edge) begin
              locked <= 1'b1;
            end else begin
              locked  <= 1'b0;
              state_q <= HUNT;
            end
          end else if (sync_edge) begin
            // Early SYNC: drop the partial frame and realign to the new one.
            frame_error <= 1'b1;
            locked      <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            case (cnt_q)
              TAG_END: tag_q   <= shift_d[15:11];
              S1_END:  addr_q  <= shift_d[18:12];
              S2_END:  data_q  <= shift_d[19:4];
              S3_END:  left_q  <= shift_d[SLOT_W-1 -: PCM_BITS];
              S4_END:  right_q <= shift_d[SLOT_W-1 -: PCM_BITS];
              default: ;
            endcase
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

endmodule
